// File: rtl/data_memory_banked.sv
// Byte-addressed little-endian data memory with a valid/ready port, registered response and a
// post-reset clear sweep. Define DMEM_MISALIGN_CHECK_EN to reject accesses not aligned to size.
module data_memory_banked #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned TAP_BASE    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy,
    output logic [63:0]       tap0,
    output logic [63:0]       tap1,
    output logic [63:0]       tap2
);

    localparam int unsigned WORDS  = DEPTH_BYTES / 8;
    localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BIDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic {StInit, StIdle} state_e;

    state_e            state_q, state_d;
    logic [WIDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]        mem [DEPTH_BYTES];

    logic              rsp_valid_q;
    logic [63:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [3:0]        nbytes;
    logic [ADDR_W:0]   end_addr;
    logic              range_err;
    logic              align_err;
    logic              acc_err;
    logic              fire;
    logic [BIDX_W-1:0] base;
    logic [63:0]       raw;
    logic [63:0]       ext;
    logic [191:0]      tap_all;

    // Sweep state machine
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == StInit) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == WIDX_W'(WORDS - 1)) begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StInit;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign init_busy = (state_q == StInit);
    assign req_ready = (state_q == StIdle);

    // Range check is one bit wider than the address so a wrapping end address is caught
    assign nbytes    = 4'd1 << req_size;
    assign end_addr  = {1'b0, req_addr} + (ADDR_W + 1)'(nbytes);
    assign range_err = end_addr > (ADDR_W + 1)'(DEPTH_BYTES);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic [2:0] align_mask;
    assign align_mask = 3'(nbytes - 4'd1);
    assign align_err  = (req_addr[2:0] & align_mask) != 3'd0;
`else
    assign align_err = 1'b0;
`endif

    assign acc_err = range_err | align_err;
    assign fire    = req_valid & req_ready & reset_n;
    assign base    = req_addr[BIDX_W-1:0];

    always_comb begin
        raw = '0;
        for (int k = 0; k < 8; k++) begin
            if (!acc_err && k < int'(nbytes)) begin
                raw[8*k +: 8] = mem[BIDX_W'(base + BIDX_W'(k))];
            end
        end
    end

    always_comb begin
        ext = raw;
        if (!req_unsigned) begin
            case (req_size)
                2'd0:    ext = {{56{raw[7]}}, raw[7:0]};
                2'd1:    ext = {{48{raw[15]}}, raw[15:0]};
                2'd2:    ext = {{32{raw[31]}}, raw[31:0]};
                default: ext = raw;
            endcase
        end
    end

    // Per-byte write ports: the sweep clears one doubleword, a store hits bytes base..base+N-1
    for (genvar i = 0; i < int'(DEPTH_BYTES); i++) begin : g_byte
        logic [BIDX_W:0] off;
        logic            init_hit;
        logic            store_hit;

        assign off       = (BIDX_W + 1)'(i) - {1'b0, base};
        assign init_hit  = (state_q == StInit) && (WIDX_W'(i / 8) == ptr_q);
        assign store_hit = fire && req_we && !acc_err && (off < (BIDX_W + 1)'(nbytes));

        always_ff @(posedge clk) begin
            if (reset_n) begin
                if (init_hit) begin
                    mem[i] <= 8'h00;
                end else if (store_hit) begin
                    mem[i] <= req_wdata[8*off[2:0] +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= fire;
            if (fire) begin
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (req_we || acc_err) ? 64'd0 : ext;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    for (genvar g = 0; g < 24; g++) begin : g_tap
        assign tap_all[8*g +: 8] = mem[TAP_BASE + g];
    end

    assign tap0 = tap_all[63:0];
    assign tap1 = tap_all[127:64];
    assign tap2 = tap_all[191:128];

endmodule

// File: tb/tb_data_memory_banked.sv
// Scoreboarded random/directed bench for data_memory_banked against a byte-array reference model.
module tb_data_memory_banked;

    localparam int unsigned DEPTH = 256;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;
    logic [63:0] tap0, tap1, tap2;

    data_memory_banked #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_W     (64),
        .TAP_BASE   (0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .init_busy   (init_busy),
        .tap0        (tap0),
        .tap1        (tap1),
        .tap2        (tap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    byte unsigned ref_mem [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference behaviour from the access rules: size -> byte count, bounds, extension
    function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  output logic [63:0] d, output bit e);
        int          n;
        logic [64:0] last;
        logic [63:0] v;
        n    = 1 << size;
        last = {1'b0, addr} + 65'(n);
        v    = '0;
        d    = '0;
        e    = last > 65'(DEPTH);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (addr % n != 0) e = 1'b1;
`endif
        if (e) return;
        for (int i = 0; i < n; i++) begin
            if (we) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            else    v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        end
        if (!we) begin
            if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
            d = v;
        end
    endfunction

    function automatic logic [63:0] ref_dw(input int a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[a + i];
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
    endtask

    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input bit has_lit, input logic [63:0] lit_d, input bit lit_e);
        logic [63:0] d;
        bit          e;
        exp_t        x;
        chk("req_ready_at_issue", {63'd0, req_ready}, 64'd1);
        model(we, size, uns, addr, wdata, d, e);
        if (has_lit) begin
            d = lit_d;
            e = lit_e;
        end
        x.d = d;
        x.e = e;
        exp_q.push_back(x);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_init(output int cyc);
        cyc = 0;
        while (init_busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t x;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                x = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, x.d);
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, x.e});
            end
        end
    end

    initial begin
        int          cyc;
        bit          we;
        logic [1:0]  sz;
        logic [63:0] a;

        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("reset_init_busy", {63'd0, init_busy}, 64'd1);

        reset_n = 1'b1;
        wait_init(cyc);
        chk("init_cycles", 64'(cyc), 64'd32);
        chk("ready_after_init", {63'd0, req_ready}, 64'd1);
        chk("tap0_init", tap0, 64'd0);
        chk("tap1_init", tap1, 64'd0);
        chk("tap2_init", tap2, 64'd0);

        // Directed little-endian and extension cases
        issue(1, 2'd3, 0, 64'd0, 64'h8877665544332211, 1, 64'd0, 0);
        chk("tap0_after_store", tap0, 64'h8877665544332211);
        issue(0, 2'd0, 0, 64'd0, 64'd0, 1, 64'h11, 0);
        issue(0, 2'd1, 1, 64'd6, 64'd0, 1, 64'h8877, 0);
        issue(0, 2'd2, 0, 64'd4, 64'd0, 1, 64'hFFFFFFFF88776655, 0);
        issue(1, 2'd0, 0, 64'd8, 64'h80, 1, 64'd0, 0);
        issue(0, 2'd0, 0, 64'd8, 64'd0, 1, 64'hFFFFFFFFFFFFFF80, 0);
        issue(0, 2'd0, 1, 64'd8, 64'd0, 1, 64'h80, 0);
        chk("tap1_low_byte", {56'd0, tap1[7:0]}, 64'h80);

        // Range errors including address wrap
        issue(0, 2'd3, 0, 64'(DEPTH - 4), 64'd0, 1, 64'd0, 1);
        issue(1, 2'd3, 0, 64'(DEPTH), 64'hDEADBEEFCAFEF00D, 1, 64'd0, 1);
        issue(0, 2'd1, 1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 64'd0, 1);
        issue(1, 2'd0, 0, 64'hFFFFFFFFFFFFFFFF, 64'h55, 1, 64'd0, 1);
        chk("tap0_after_err", tap0, 64'h8877665544332211);
        chk("tap1_after_err", tap1, 64'h80);
        chk("tap2_after_err", tap2, 64'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
        issue(0, 2'd2, 0, 64'd2, 64'd0, 1, 64'd0, 1);
`else
        issue(0, 2'd2, 0, 64'd2, 64'd0, 1, 64'h66554433, 0);
`endif

        // Store then dependent load on consecutive cycles
        issue(1, 2'd0, 0, 64'd16, 64'hAB, 1, 64'd0, 0);
        issue(0, 2'd0, 1, 64'd16, 64'd0, 1, 64'hAB, 0);
        idle(2);
        chk("drained_directed", 64'(exp_q.size()), 64'd0);

        // Randomised traffic, occasionally spaced out
        repeat (300) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, DEPTH + 4));
            issue(we, sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 0, 64'd0, 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
        chk("drained_random", 64'(exp_q.size()), 64'd0);
        chk("tap0_random", tap0, ref_dw(0));
        chk("tap1_random", tap1, ref_dw(8));
        chk("tap2_random", tap2, ref_dw(16));

        // Reset between a store and its follow-up load drops the load
        issue(1, 2'd0, 0, 64'd16, 64'hAB, 1, 64'd0, 0);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b1;
        req_addr     = 64'd16;
        reset_n      = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midreset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midreset_init_busy", {63'd0, init_busy}, 64'd1);
        reset_n = 1'b1;
        clear_model();
        wait_init(cyc);
        chk("reinit_cycles", 64'(cyc), 64'd32);
        chk("tap0_reinit", tap0, 64'd0);
        chk("tap2_reinit", tap2, 64'd0);
        issue(0, 2'd0, 1, 64'd16, 64'd0, 1, 64'd0, 0);
        idle(3);
        chk("drained_final", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
